// File: rtl/finv_issue_arbiter_pkg.sv
// Shared types and helpers for the finv issue arbiter: response entry layout
// and the round-robin pick function.
package finv_issue_arbiter_pkg;

  localparam int FLOAT_W = 32;
  localparam int MAX_REQ = 64;
  localparam int MAX_IDW = 6;

  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic [FLOAT_W-1:0] y;
    logic               ovf;
    logic               udf;
  } finv_resp_t;

  // First set bit of valid at or above ptr, wrapping at nreq; returns ptr when nothing is set.
  function automatic int rr_pick(input logic [MAX_REQ-1:0] valid, input int ptr, input int nreq);
    int   idx;
    logic found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int k = 0; k < MAX_REQ; k++) begin
      idx = ptr + k;
      if (idx >= nreq) idx = idx - nreq;
      if (k < nreq && !found && valid[idx[MAX_IDW-1:0]]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/finv_issue_arbiter_if.sv
// Bundle of requester, finv pipeline and response signals around the arbiter.
// The arbiter uses the slave modport; its environment uses master.
interface finv_issue_arbiter_if #(parameter int NREQ = 2);
  import finv_issue_arbiter_pkg::*;

  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]         req_valid;
  logic [NREQ*FLOAT_W-1:0] req_x;
  logic [NREQ-1:0]         req_ready;
  logic [FLOAT_W-1:0]      finv_x;
  logic [FLOAT_W-1:0]      finv_y;
  logic                    finv_ovf;
  logic                    finv_udf;
  logic                    resp_valid;
  logic                    resp_ready;
  logic [IDW-1:0]          resp_id;
  logic [FLOAT_W-1:0]      resp_y;
  logic                    resp_ovf;
  logic                    resp_udf;

  modport master (
    output req_valid, req_x, resp_ready, finv_y, finv_ovf, finv_udf,
    input  req_ready, finv_x, resp_valid, resp_id, resp_y, resp_ovf, resp_udf
  );

  modport slave (
    input  req_valid, req_x, resp_ready, finv_y, finv_ovf, finv_udf,
    output req_ready, finv_x, resp_valid, resp_id, resp_y, resp_ovf, resp_udf
  );

endinterface

// File: rtl/finv_issue_arbiter_resp_fifo.sv
// Ordered response FIFO for finv results. Head is read straight from storage
// registers; push and pop may coincide even when full.
module finv_resp_fifo
  import finv_issue_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  finv_resp_t push_data,
  input  logic       pop,
  output logic       not_empty,
  output logic       full,
  output finv_resp_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  finv_resp_t     mem [DEPTH];
  logic [PW-1:0]  wrPtr;
  logic [PW-1:0]  rdPtr;
  logic [CW-1:0]  count;
  logic           doPush;
  logic           doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    not_empty = (count != '0);
    full      = (count == CW'(DEPTH));
    doPop     = pop && not_empty;
    doPush    = push && (!full || doPop);
    head      = mem[rdPtr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= nextPtr(wrPtr);
      if (doPop)  rdPtr <= nextPtr(rdPtr);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: nothing is visible until count says so.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= push_data;
  end

  assert property (@(posedge clk) disable iff (rst) !(push && full && !pop));

endmodule

// File: rtl/finv_issue_arbiter.sv
// Round-robin issue of NREQ requesters onto one fixed-latency finv pipeline,
// with an id tag pipe, credit counter and ordered response FIFO.
module finv_issue_arbiter
  import finv_issue_arbiter_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int LAT   = 3,
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  finv_issue_arbiter_if.slave  bus
);

  localparam int IDW = $clog2(NREQ);
  localparam int CW  = $clog2(DEPTH + 1);

  logic [MAX_REQ-1:0]        validWide;
  logic [IDW-1:0]            rrPtr;
  logic [IDW-1:0]            grantId;
  logic [CW-1:0]             credits;
  logic                      issue;
  logic                      pop;
  logic [LAT-1:0]            tagValid;
  logic [LAT-1:0][IDW-1:0]   tagId;
  finv_resp_t                pushData;
  finv_resp_t                head;
  logic                      fifoFull;
  logic                      unusedHeadId;

  always_comb begin
    validWide                = '0;
    validWide[NREQ-1:0]      = bus.req_valid;
    grantId                  = IDW'(rr_pick(validWide, int'(rrPtr), NREQ));
    issue                    = !rst && (|bus.req_valid) && (credits != '0);
    pop                      = bus.resp_valid && bus.resp_ready;
    bus.req_ready            = '0;
    bus.finv_x               = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (issue && grantId == IDW'(i)) begin
        bus.req_ready[i] = 1'b1;
        bus.finv_x       = bus.req_x[i*FLOAT_W +: FLOAT_W];
      end
    end
  end

  // A credit taken on issue comes back only when its result leaves the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      rrPtr    <= '0;
      credits  <= CW'(DEPTH);
      tagValid <= '0;
      tagId    <= '0;
    end else begin
      if (issue) rrPtr <= (grantId == IDW'(NREQ - 1)) ? '0 : grantId + IDW'(1);
      case ({issue, pop})
        2'b10:   credits <= credits - CW'(1);
        2'b01:   credits <= credits + CW'(1);
        default: credits <= credits;
      endcase
      tagValid[0] <= issue;
      tagId[0]    <= grantId;
      for (int i = 1; i < LAT; i++) begin
        tagValid[i] <= tagValid[i-1];
        tagId[i]    <= tagId[i-1];
      end
    end
  end

  always_comb begin
    pushData             = '0;
    pushData.id[IDW-1:0] = tagId[LAT-1];
    pushData.y           = bus.finv_y;
    pushData.ovf         = bus.finv_ovf;
    pushData.udf         = bus.finv_udf;
  end

  finv_resp_fifo #(.DEPTH(DEPTH)) u_resp_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tagValid[LAT-1]),
    .push_data (pushData),
    .pop       (bus.resp_ready),
    .not_empty (bus.resp_valid),
    .full      (fifoFull),
    .head      (head)
  );

  always_comb begin
    bus.resp_id  = head.id[IDW-1:0];
    bus.resp_y   = head.y;
    bus.resp_ovf = head.ovf;
    bus.resp_udf = head.udf;
    unusedHeadId = ^head.id ^ fifoFull;
  end

endmodule

// File: tb/tb_finv_issue_arbiter.sv
// Self-checking bench for finv_issue_arbiter: directed scenarios plus random
// traffic, scored against a queue-based reference of issue order and credits.
module tb_finv_issue_arbiter;
  import finv_issue_arbiter_pkg::*;

  localparam int NREQ  = 2;
  localparam int LAT   = 3;
  localparam int DEPTH = 4;

  typedef struct {
    int          id;
    logic [31:0] y;
    logic        ovf;
    logic        udf;
    int          readyCycle;
  } expItem_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  finv_issue_arbiter_if #(.NREQ(NREQ)) bus ();

  finv_issue_arbiter #(.NREQ(NREQ), .LAT(LAT), .DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int compareCount  = 0;
  int mismatchCount = 0;
  int cycleNum      = 0;
  int issueCount    = 0;
  int refPtr        = 0;
  int refCredits    = DEPTH;
  expItem_t expQ[$];

  // Reference reciprocal: exact quotient with round-to-nearest-even, flush-to-zero underflow,
  // zero exponent treated as zero (infinity with overflow flag).
  function automatic logic [33:0] finvModel(input logic [31:0] x);
    logic        s;
    int          e;
    int          ex;
    logic [63:0] m;
    logic [63:0] q;
    logic [63:0] r;
    logic [23:0] sig;
    s = x[31];
    e = int'(x[30:23]);
    if (e == 0)   return {s, 8'hff, 23'd0, 1'b1, 1'b0};
    if (e == 255) return {s, 31'd0, 2'b00};
    if (x[22:0] == 23'd0) begin
      ex  = 254 - e;
      sig = 24'h800000;
    end else begin
      m   = {40'd0, 1'b1, x[22:0]};
      q   = (64'd1 << 48) / m;
      r   = (64'd1 << 48) % m;
      sig = q[24:1];
      ex  = 253 - e;
      if (q[0] && (r != 64'd0 || sig[0])) sig = sig + 24'd1;
      if (sig == 24'd0) begin
        sig = 24'h800000;
        ex  = ex + 1;
      end
    end
    if (ex <= 0) return {s, 31'd0, 1'b0, 1'b1};
    return {s, 8'(ex), sig[22:0], 2'b00};
  endfunction

  function automatic logic [31:0] genX();
    logic [7:0] e;
    e = ($urandom_range(0, 15) == 0) ? 8'd0 : 8'($urandom_range(1, 254));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  // Behavioural finv unit: fixed LAT-cycle delay, never reset, so stale values do emerge.
  logic [33:0] finvPipe [LAT];
  always @(posedge clk) begin
    finvPipe[0] <= finvModel(bus.finv_x);
    for (int i = 1; i < LAT; i++) finvPipe[i] <= finvPipe[i-1];
  end
  assign bus.finv_y   = finvPipe[LAT-1][33:2];
  assign bus.finv_ovf = finvPipe[LAT-1][1];
  assign bus.finv_udf = finvPipe[LAT-1][0];

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: observed %h expected %h (cycle %0d)", tag, observed, expected, cycleNum);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [NREQ-1:0] v,
                               input logic [31:0] x0, input logic [31:0] x1, input logic rr);
    rst            = r;
    bus.req_valid  = v;
    bus.req_x      = {x1, x0};
    bus.resp_ready = rr;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference scoreboard evaluated mid-cycle on settled inputs and outputs.
  int                      g;
  int                      cand;
  logic [NREQ-1:0]         expReady;
  logic [31:0]             expX;
  logic [NREQ*32-1:0]      xShift;
  logic                    expValid;
  logic [33:0]             res;
  expItem_t                item;
  expItem_t                head;

  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
      expQ.delete();
      refPtr     = 0;
      refCredits = DEPTH;
    end else begin
      g = -1;
      if (refCredits > 0) begin
        for (int k = 0; k < NREQ; k++) begin
          cand = (refPtr + k) % NREQ;
          if (g < 0 && ((bus.req_valid >> cand) & 1) != 0) g = cand;
        end
      end
      expReady = '0;
      expX     = '0;
      if (g >= 0) begin
        expReady = NREQ'(1) << g;
        xShift   = bus.req_x >> (32 * g);
        expX     = xShift[31:0];
      end
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));
      checkOutput("finv_x", bus.finv_x, expX);
      expValid = (expQ.size() > 0) && (expQ[0].readyCycle <= cycleNum);
      checkOutput("resp_valid", 32'(bus.resp_valid), 32'(expValid));
      if (expValid && bus.resp_valid) begin
        head = expQ[0];
        checkOutput("resp_id",  32'(bus.resp_id),  32'(head.id));
        checkOutput("resp_y",   bus.resp_y,        head.y);
        checkOutput("resp_ovf", 32'(bus.resp_ovf), 32'(head.ovf));
        checkOutput("resp_udf", 32'(bus.resp_udf), 32'(head.udf));
      end
      if (expValid && bus.resp_ready) begin
        void'(expQ.pop_front());
        refCredits++;
      end
      if (g >= 0) begin
        res             = finvModel(expX);
        item.id         = g;
        item.y          = res[33:2];
        item.ovf        = res[1];
        item.udf        = res[0];
        item.readyCycle = cycleNum + LAT + 1;
        expQ.push_back(item);
        refCredits--;
        refPtr = (g + 1) % NREQ;
        issueCount++;
      end
    end
    cycleNum++;
  end

  int issuesBefore;

  initial begin
    applyStimulus(1'b1, '0, 32'd0, 32'd0, 1'b0);
    step(2);

    // Reset state and single request latency.
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(2);
    checkOutput("reset_resp_valid", 32'(bus.resp_valid), 32'd0);
    applyStimulus(1'b0, 2'b01, 32'h40000000, 32'd0, 1'b1);
    #1;
    checkOutput("t1_finv_x", bus.finv_x, 32'h40000000);
    checkOutput("t1_grant", 32'(bus.req_ready), 32'd1);
    step(1);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(LAT - 1);
    checkOutput("t1_not_early", 32'(bus.resp_valid), 32'd0);
    step(1);
    checkOutput("t1_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("t1_resp_id", 32'(bus.resp_id), 32'd0);
    checkOutput("t1_resp_y", bus.resp_y, 32'h3f000000);
    step(3);

    // Both requesters streaming; each credit is out for LAT+2 cycles (issue, LAT in flight,
    // FIFO head cycle, then released a cycle later), so DEPTH issues per LAT+2 cycles.
    applyStimulus(1'b0, 2'b11, 32'h3f800000, 32'h40800000, 1'b1);
    step(5);
    issuesBefore = issueCount;
    step(5 * (LAT + 2));
    checkOutput("t2_issue_rate", 32'(issueCount - issuesBefore), 32'(5 * DEPTH));
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(10);

    // Consumer stalled: exactly DEPTH issues, then blocked until a pop frees a credit.
    applyStimulus(1'b0, 2'b11, 32'h3f800000, 32'h40800000, 1'b0);
    issuesBefore = issueCount;
    step(12);
    checkOutput("t3_issue_count", 32'(issueCount - issuesBefore), 32'(DEPTH));
    checkOutput("t3_blocked", 32'(bus.req_ready), 32'd0);
    checkOutput("t3_fifo_head", 32'(bus.resp_valid), 32'd1);
    applyStimulus(1'b0, 2'b11, 32'h3f800000, 32'h40800000, 1'b1);
    #1;
    checkOutput("t3_no_same_cycle", 32'(bus.req_ready), 32'd0);
    step(1);
    checkOutput("t3_regrant", 32'(|bus.req_ready), 32'd1);
    step(12);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(10);

    // Reset with two operations in flight.
    applyStimulus(1'b0, 2'b01, 32'h3f800000, 32'h40800000, 1'b1);
    step(1);
    applyStimulus(1'b0, 2'b10, 32'h3f800000, 32'h40800000, 1'b1);
    step(1);
    applyStimulus(1'b1, '0, 32'd0, 32'd0, 1'b1);
    step(1);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    for (int i = 0; i < 2 * LAT; i++) begin
      checkOutput("t5_quiet", 32'(bus.resp_valid), 32'd0);
      step(1);
    end
    applyStimulus(1'b0, 2'b01, 32'hbf000000, 32'd0, 1'b1);
    #1;
    checkOutput("t5_grant", 32'(bus.req_ready), 32'd1);
    step(1);
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(LAT);
    checkOutput("t5_resp_valid", 32'(bus.resp_valid), 32'd1);
    checkOutput("t5_resp_y", bus.resp_y, 32'hc0000000);
    step(4);

    // Random traffic with random consumer backpressure.
    for (int i = 0; i < 2000; i++) begin
      applyStimulus(1'b0, NREQ'($urandom_range(0, 3)), genX(), genX(), $urandom_range(0, 9) < 7);
      step(1);
    end
    applyStimulus(1'b0, '0, 32'd0, 32'd0, 1'b1);
    step(20);
    checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    checkOutput("drain_resp_valid", 32'(bus.resp_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
